// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the datapath load/store port.
// Accepts one request at a time and returns a single-cycle response after LATENCY cycles.
module dmem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               cap_write;
  logic [63:0]        cap_addr;
  logic [1:0]         cap_size;
  logic [63:0]        cap_wdata;

  logic [63:0]        mem [DEPTH];

  logic               src_write;
  logic [63:0]        src_addr;
  logic [1:0]         src_size;
  logic [63:0]        src_wdata;
  logic [ADDR_W-1:0]  idx;
  logic [5:0]         shamt;
  logic               range_err;
  logic               align_err;
  logic               err;
  logic [63:0]        size_mask;
  logic [63:0]        word;
  logic [63:0]        load_data;
  logic [63:0]        merged;
  logic               mem_we;

  // With LATENCY=1 the response is built on the acceptance edge, so decode the live request in IDLE.
  always_comb begin
    src_write = cap_write;
    src_addr  = cap_addr;
    src_size  = cap_size;
    src_wdata = cap_wdata;
    if (state == IDLE) begin
      src_write = req_write;
      src_addr  = req_addr;
      src_size  = req_size;
      src_wdata = req_wdata;
    end
  end

  // Address decode, alignment check and lane select/merge.
  always_comb begin
    idx       = src_addr[ADDR_W+2:3];
    shamt     = {src_addr[2:0], 3'b000};
    range_err = |src_addr[63:ADDR_W+3];
    align_err = 1'b0;
    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (src_size)
      2'd0: size_mask = 64'h0000_0000_0000_00FF;
      2'd1: begin
        size_mask = 64'h0000_0000_0000_FFFF;
        align_err = src_addr[0];
      end
      2'd2: begin
        size_mask = 64'h0000_0000_FFFF_FFFF;
        align_err = |src_addr[1:0];
      end
      default: begin
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        align_err = |src_addr[2:0];
      end
    endcase
    err       = range_err | align_err;
    word      = mem[idx];
    load_data = (word >> shamt) & size_mask;
    merged    = (word & ~(size_mask << shamt)) | ((src_wdata & size_mask) << shamt);
    mem_we    = (state == RESP) && cap_write && !err;
  end

  // Array is not reset; the store lands on the edge that ends the response cycle.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_size   <= '0;
      cap_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_size  <= req_size;
            cap_wdata <= req_wdata;
            cnt       <= CNT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= err;
              resp_rdata <= (err || src_write) ? 64'd0 : load_data;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= err;
            resp_rdata <= (err || src_write) ? 64'd0 : load_data;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
